// File: rtl/character_anim_fsm.sv
// Per-character animation sequencer: level requests -> action state, sprite frame, strobes, pulses.
// Latency: updates 2 Clk after a frame_clk rise is sampled; no backpressure (requests are levels, sampled on ticks).
module character_anim_fsm #(
    parameter int DLY_W       = 8,
    parameter int FRAME_W     = 8,
    parameter int CD_W        = 8,
    parameter int DLY_STAND   = 10,
    parameter int DLY_MOVE    = 10,
    parameter int DLY_ATTACK  = 3,
    parameter int DLY_DEF     = 10,
    parameter int DLY_HURT    = 10,
    parameter int LAST_STAND  = 8,
    parameter int LAST_MOVER  = 8,
    parameter int LAST_MOVEL  = 9,
    parameter int LAST_ATTACK = 5,
    parameter int LAST_DEF    = 0,
    parameter int LAST_HURT   = 4,
    parameter int ATTACK_CD   = 16,
    parameter bit FACE_INIT   = 1'b1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               req_attack,
    input  logic               req_move_r,
    input  logic               req_move_l,
    input  logic               req_defense,
    input  logic               req_hurt,
    output logic [2:0]         state_out,
    output logic [FRAME_W-1:0] frame_num,
    output logic               stand,
    output logic               attack,
    output logic               move_l,
    output logic               move_r,
    output logic               facing,
    output logic               anim_done,
    output logic               hit_blocked,
    output logic               cooldown_active
);

    typedef enum logic [2:0] {
        ST_STAND   = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_MOVE_L  = 3'd2,
        ST_MOVE_R  = 3'd3,
        ST_DEFENSE = 3'd4,
        ST_HURT    = 3'd5
    } state_t;

    localparam logic [DLY_W-1:0]   D_STAND  = DLY_W'(DLY_STAND);
    localparam logic [DLY_W-1:0]   D_MOVE   = DLY_W'(DLY_MOVE);
    localparam logic [DLY_W-1:0]   D_ATTACK = DLY_W'(DLY_ATTACK);
    localparam logic [DLY_W-1:0]   D_DEF    = DLY_W'(DLY_DEF);
    localparam logic [DLY_W-1:0]   D_HURT   = DLY_W'(DLY_HURT);
    localparam logic [FRAME_W-1:0] L_STAND  = FRAME_W'(LAST_STAND);
    localparam logic [FRAME_W-1:0] L_MOVER  = FRAME_W'(LAST_MOVER);
    localparam logic [FRAME_W-1:0] L_MOVEL  = FRAME_W'(LAST_MOVEL);
    localparam logic [FRAME_W-1:0] L_ATTACK = FRAME_W'(LAST_ATTACK);
    localparam logic [FRAME_W-1:0] L_DEF    = FRAME_W'(LAST_DEF);
    localparam logic [FRAME_W-1:0] L_HURT   = FRAME_W'(LAST_HURT);
    localparam logic [CD_W-1:0]    CD_LOAD  = CD_W'(ATTACK_CD);

    state_t             state, state_nxt, winner;
    logic [DLY_W-1:0]   delay, delay_nxt, dly_lim;
    logic [FRAME_W-1:0] frame_nxt, last_lim;
    logic [FRAME_W-1:0] adv_frame_loop, adv_frame_sat;
    logic [DLY_W-1:0]   adv_delay;
    logic [CD_W-1:0]    cooldown, cd_nxt;
    logic               facing_nxt, done_nxt, blocked_nxt;
    logic               frame_clk_d, tick;
    logic               frame_due, at_last;

    // Rising-edge detect of the slow frame clock; reset preloads history so no edge follows reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= frame_clk;
            tick        <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            tick        <= frame_clk & ~frame_clk_d;
        end
    end

    always_comb begin
        dly_lim  = D_STAND;
        last_lim = L_STAND;
        case (state)
            ST_ATTACK:  begin dly_lim = D_ATTACK; last_lim = L_ATTACK; end
            ST_MOVE_L:  begin dly_lim = D_MOVE;   last_lim = L_MOVEL;  end
            ST_MOVE_R:  begin dly_lim = D_MOVE;   last_lim = L_MOVER;  end
            ST_DEFENSE: begin dly_lim = D_DEF;    last_lim = L_DEF;    end
            ST_HURT:    begin dly_lim = D_HURT;   last_lim = L_HURT;   end
            default:    begin dly_lim = D_STAND;  last_lim = L_STAND;  end
        endcase
    end

    assign frame_due = (delay >= dly_lim);
    assign at_last   = (frame_num >= last_lim);

    always_comb begin
        adv_delay      = delay + DLY_W'(1);
        adv_frame_loop = frame_num;
        adv_frame_sat  = frame_num;
        if (frame_due) begin
            adv_delay      = '0;
            adv_frame_loop = at_last ? '0 : frame_num + FRAME_W'(1);
            adv_frame_sat  = at_last ? frame_num : frame_num + FRAME_W'(1);
        end
    end

    // Request priority for the interruptible states; uses the pre-tick cooldown value.
    always_comb begin
        winner = ST_STAND;
        if (req_hurt)
            winner = ST_HURT;
        else if (req_attack && (cooldown == '0))
            winner = ST_ATTACK;
        else if (req_defense)
            winner = ST_DEFENSE;
        else if (req_move_r && !req_move_l)
            winner = ST_MOVE_R;
        else if (req_move_l && !req_move_r)
            winner = ST_MOVE_L;
    end

    always_comb begin
        state_nxt   = state;
        delay_nxt   = delay;
        frame_nxt   = frame_num;
        cd_nxt      = cooldown;
        facing_nxt  = facing;
        done_nxt    = 1'b0;
        blocked_nxt = 1'b0;
        if (tick) begin
            if (cooldown != '0)
                cd_nxt = cooldown - CD_W'(1);
            case (state)
                ST_STAND, ST_MOVE_L, ST_MOVE_R: begin
                    if (winner == state) begin
                        delay_nxt = adv_delay;
                        frame_nxt = adv_frame_loop;
                    end else begin
                        state_nxt = winner;
                        delay_nxt = '0;
                        frame_nxt = '0;
                        if (winner == ST_MOVE_R)
                            facing_nxt = 1'b1;
                        else if (winner == ST_MOVE_L)
                            facing_nxt = 1'b0;
                    end
                end
                ST_ATTACK: begin
                    if (req_hurt) begin
                        state_nxt = ST_HURT;
                        delay_nxt = '0;
                        frame_nxt = '0;
                    end else if (frame_due && at_last) begin
                        state_nxt = ST_STAND;
                        delay_nxt = '0;
                        frame_nxt = '0;
                        done_nxt  = 1'b1;
                        cd_nxt    = CD_LOAD;
                    end else begin
                        delay_nxt = adv_delay;
                        frame_nxt = adv_frame_loop;
                    end
                end
                ST_HURT: begin
                    if (frame_due && at_last) begin
                        state_nxt = ST_STAND;
                        delay_nxt = '0;
                        frame_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        delay_nxt = adv_delay;
                        frame_nxt = adv_frame_loop;
                    end
                end
                ST_DEFENSE: begin
                    // A hit while guarding is absorbed even if the guard is being dropped this tick.
                    if (req_hurt) begin
                        blocked_nxt = 1'b1;
                        delay_nxt   = adv_delay;
                        frame_nxt   = adv_frame_sat;
                    end else if (!req_defense) begin
                        state_nxt = ST_STAND;
                        delay_nxt = '0;
                        frame_nxt = '0;
                    end else begin
                        delay_nxt = adv_delay;
                        frame_nxt = adv_frame_sat;
                    end
                end
                default: begin
                    state_nxt = ST_STAND;
                    delay_nxt = '0;
                    frame_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= ST_STAND;
            delay       <= '0;
            frame_num   <= '0;
            cooldown    <= '0;
            facing      <= FACE_INIT;
            anim_done   <= 1'b0;
            hit_blocked <= 1'b0;
            stand       <= 1'b0;
            attack      <= 1'b0;
            move_l      <= 1'b0;
            move_r      <= 1'b0;
        end else begin
            state       <= state_nxt;
            delay       <= delay_nxt;
            frame_num   <= frame_nxt;
            cooldown    <= cd_nxt;
            facing      <= facing_nxt;
            anim_done   <= done_nxt;
            hit_blocked <= blocked_nxt;
            if (tick) begin
                stand  <= (state_nxt == ST_STAND);
                attack <= (state_nxt == ST_ATTACK);
                move_l <= (state_nxt == ST_MOVE_L);
                move_r <= (state_nxt == ST_MOVE_R);
            end
        end
    end

    assign state_out       = state;
    assign cooldown_active = (cooldown != '0);

endmodule

// File: tb/tb_character_anim_fsm.sv
// Bench for character_anim_fsm: tick-level reference model with per-cycle compare plus literal scenario checks.
module tb_character_anim_fsm;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b1;
    logic       req_attack = 1'b0, req_move_r = 1'b0, req_move_l = 1'b0;
    logic       req_defense = 1'b0, req_hurt = 1'b0;
    logic [2:0] state_out;
    logic [7:0] frame_num;
    logic       stand, attack, move_l, move_r, facing;
    logic       anim_done, hit_blocked, cooldown_active;

    int total = 0;
    int bad   = 0;

    character_anim_fsm dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .req_attack(req_attack), .req_move_r(req_move_r), .req_move_l(req_move_l),
        .req_defense(req_defense), .req_hurt(req_hurt),
        .state_out(state_out), .frame_num(frame_num),
        .stand(stand), .attack(attack), .move_l(move_l), .move_r(move_r),
        .facing(facing), .anim_done(anim_done), .hit_blocked(hit_blocked),
        .cooldown_active(cooldown_active)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: state plus ticks-elapsed-in-state; frame and delay are derived arithmetically.
    int m_st, m_t, m_cd, m_face, m_done, m_blk, m_sv, m_tick, m_fcd;
    int m_valid = 0;

    function automatic int dly_of(input int s);
        case (s)
            1:       return 3;
            default: return 10;
        endcase
    endfunction

    function automatic int last_of(input int s);
        case (s)
            0: return 8;
            1: return 5;
            2: return 9;
            3: return 8;
            4: return 0;
            default: return 4;
        endcase
    endfunction

    function automatic int period(input int s);
        return (dly_of(s) + 1) * (last_of(s) + 1);
    endfunction

    function automatic int frame_of(input int s, input int t);
        int f;
        f = t / (dly_of(s) + 1);
        if (f > last_of(s)) f = last_of(s);
        return f;
    endfunction

    function automatic int pick(input int cd);
        if (req_hurt) return 5;
        if (req_attack && cd == 0) return 1;
        if (req_defense) return 4;
        if (req_move_r && !req_move_l) return 3;
        if (req_move_l && !req_move_r) return 2;
        return 0;
    endfunction

    task automatic m_enter(input int w);
        m_st = w;
        m_t  = 0;
        if (w == 3) m_face = 1;
        if (w == 2) m_face = 0;
    endtask

    always @(posedge Clk) begin
        int cd_pre, w;
        if (Reset) begin
            m_st = 0; m_t = 0; m_cd = 0; m_face = 1;
            m_done = 0; m_blk = 0; m_sv = 0; m_tick = 0;
            m_fcd = frame_clk; m_valid = 1;
        end else if (m_valid != 0) begin
            m_done = 0;
            m_blk  = 0;
            if (m_tick != 0) begin
                cd_pre = m_cd;
                if (m_cd > 0) m_cd--;
                m_sv = 1;
                case (m_st)
                    0, 2, 3: begin
                        w = pick(cd_pre);
                        if (w == m_st) m_t = (m_t + 1) % period(m_st);
                        else m_enter(w);
                    end
                    1: begin
                        if (req_hurt) m_enter(5);
                        else if (m_t == period(1) - 1) begin
                            m_enter(0); m_done = 1; m_cd = 16;
                        end else m_t++;
                    end
                    5: begin
                        if (m_t == period(5) - 1) begin
                            m_enter(0); m_done = 1;
                        end else m_t++;
                    end
                    default: begin
                        if (req_hurt) begin
                            m_blk = 1;
                            if (m_t < period(4)) m_t++;
                        end else if (!req_defense) m_enter(0);
                        else if (m_t < period(4)) m_t++;
                    end
                endcase
            end
            m_tick = (frame_clk && m_fcd == 0) ? 1 : 0;
            m_fcd  = frame_clk;
        end
    end

    always @(negedge Clk) begin
        if (m_valid != 0) begin
            chk("state",       state_out,       m_st);
            chk("frame",       frame_num,       frame_of(m_st, m_t));
            chk("facing",      facing,          m_face);
            chk("anim_done",   anim_done,       m_done);
            chk("hit_blocked", hit_blocked,     m_blk);
            chk("cd_active",   cooldown_active, (m_cd != 0) ? 1 : 0);
            chk("stand",       stand,           (m_sv != 0 && m_st == 0) ? 1 : 0);
            chk("attack",      attack,          (m_sv != 0 && m_st == 1) ? 1 : 0);
            chk("move_l",      move_l,          (m_sv != 0 && m_st == 2) ? 1 : 0);
            chk("move_r",      move_r,          (m_sv != 0 && m_st == 3) ? 1 : 0);
        end
    end

    // Returns on the negedge where the tick's update (and any pulse) is first visible.
    task automatic do_tick();
        @(negedge Clk) frame_clk = 1'b0;
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    initial begin
        // Reset with frame_clk high: no tick may follow release.
        frame_clk = 1'b1;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        chk("lit_rst_state",  state_out, 0);
        chk("lit_rst_facing", facing,    1);
        chk("lit_rst_frame",  frame_num, 0);
        chk("lit_rst_stand",  stand,     0);

        // One-shot attack: 24 ticks of animation, then cooldown.
        req_attack = 1'b1;
        do_tick();
        chk("lit_atk_enter", state_out, 1);
        ticks(23);
        chk("lit_atk_lastframe", frame_num, 5);
        chk("lit_atk_still", state_out, 1);
        do_tick();
        chk("lit_atk_end_state", state_out, 0);
        chk("lit_atk_done", anim_done, 1);
        chk("lit_atk_cd", cooldown_active, 1);
        @(negedge Clk);
        chk("lit_atk_done_pulse", anim_done, 0);

        // Attack held through cooldown: 16 ticks blocked, entry on the 17th.
        ticks(16);
        chk("lit_cd_state", state_out, 0);
        chk("lit_cd_clear", cooldown_active, 0);
        do_tick();
        chk("lit_cd_reenter", state_out, 1);

        // Hurt preempts attack at frame 2; hurt lasts 55 ticks.
        req_attack = 1'b0;
        ticks(8);
        chk("lit_pre_frame", frame_num, 2);
        req_hurt = 1'b1;
        do_tick();
        chk("lit_hurt_state", state_out, 5);
        chk("lit_hurt_frame", frame_num, 0);
        chk("lit_hurt_nodone", anim_done, 0);
        ticks(3);
        req_hurt = 1'b0;
        ticks(51);
        chk("lit_hurt_last", frame_num, 4);
        do_tick();
        chk("lit_hurt_end", state_out, 0);
        chk("lit_hurt_done", anim_done, 1);

        // Held defense and blocked hit.
        req_defense = 1'b1;
        do_tick();
        chk("lit_def_state", state_out, 4);
        ticks(12);
        chk("lit_def_frame", frame_num, 0);
        req_hurt = 1'b1;
        do_tick();
        chk("lit_def_block", hit_blocked, 1);
        chk("lit_def_stay", state_out, 4);
        req_hurt = 1'b0;
        req_defense = 1'b0;
        do_tick();
        chk("lit_def_release", state_out, 0);

        // Moving left loops 10 frames per 110 ticks; both directions -> stand.
        req_move_l = 1'b1;
        do_tick();
        chk("lit_ml_state", state_out, 2);
        chk("lit_ml_face", facing, 0);
        ticks(11);
        chk("lit_ml_f1", frame_num, 1);
        ticks(98);
        chk("lit_ml_f9", frame_num, 9);
        do_tick();
        chk("lit_ml_wrap", frame_num, 0);
        req_move_r = 1'b1;
        do_tick();
        chk("lit_both_stand", state_out, 0);
        req_move_l = 1'b0;
        do_tick();
        chk("lit_mr_state", state_out, 3);
        chk("lit_mr_face", facing, 1);
        chk("lit_mr_strobe", move_r, 1);

        // Randomised traffic, occasional resets and irregular frame_clk timing.
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            req_hurt    = ($urandom % 12) == 0;
            req_attack  = ($urandom % 3) == 0;
            req_defense = ($urandom % 4) == 0;
            req_move_r  = ($urandom % 2) == 0;
            req_move_l  = ($urandom % 2) == 0;
            if (($urandom % 150) == 0) begin
                Reset = 1'b1;
                frame_clk = 1'($urandom % 2);
                repeat ($urandom_range(1, 2)) @(negedge Clk);
                Reset = 1'b0;
            end
            frame_clk = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
            frame_clk = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge Clk);
        end
        repeat (4) @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
